pll_drp_ctrl: RTL and testbench

- Runtime reconfiguration and reset sequencer for a 7-series PLLE2_ADV clock generator with four output clocks (CLKOUT0..3).
- Rewrites one output divider at a time through the PLL DRP port using read-modify-write, holding the PLL in reset while it does so.
- After the write it releases reset and waits for lock. It also performs the power-up reset hold.
- Runs on the PLL reference clock, so it sits beside the PLL wrapper and stays clocked while the PLL is unlocked.

---
 rtl/pll_drp_ctrl_if.sv | 20 ++
 rtl/pll_drp_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_drp_ctrl_if.sv
// DRP bus between the reconfiguration controller and the PLLE2_ADV dynamic port.
// master = controller side, slave = PLL (or its model) side.
interface pll_drp_ctrl_if;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_den;
    logic        drp_dwe;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_di, drp_den, drp_dwe,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_di, drp_den, drp_dwe,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/pll_drp_ctrl.sv
// PLLE2_ADV reset sequencer and output-divider rewriter: read-modify-write of
// ClkReg1/ClkReg2 over DRP while the PLL is held in reset, then wait for lock.
module pll_drp_ctrl #(
    parameter int RST_HOLD     = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_req,
    input  logic [1:0]            cfg_out,
    input  logic [6:0]            cfg_div,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic                  locked,
    output logic                  pll_rst,
    input  logic                  pll_locked,
    pll_drp_ctrl_if.master        drp
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int DRDY_W = $clog2(DRDY_TIMEOUT + 1);
    localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD);
    localparam logic [DRDY_W-1:0] DRDY_LAST = DRDY_W'(DRDY_TIMEOUT - 1);
    localparam logic [DRDY_W-1:0] DRDY_MAX  = DRDY_W'(DRDY_TIMEOUT);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_TIMEOUT);

    typedef enum logic [3:0] {
        ST_HOLD,
        ST_WAITLOCK,
        ST_IDLE,
        ST_RD1,
        ST_WT1,
        ST_WR1,
        ST_WW1,
        ST_RD2,
        ST_WT2,
        ST_WR2,
        ST_WW2
    } state_t;

    state_t              state_reg, state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [DRDY_W-1:0]   drdy_cnt_reg, drdy_cnt_next;
    logic [LOCK_W-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [1:0]          sel_reg, sel_next;
    logic [6:0]          div_reg, div_next;
    logic [15:0]         rdata_reg, rdata_next;
    logic                req_active_reg, req_active_next;
    logic                pll_rst_reg, pll_rst_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                den_reg, den_next;
    logic                dwe_reg, dwe_next;
    logic [6:0]          daddr_reg, daddr_next;
    logic [15:0]         di_reg, di_next;
    logic [1:0]          lock_sync_reg;

    logic [6:0]          addr_reg1, addr_reg2;
    logic [5:0]          enc_high, enc_low;
    logic [6:0]          low_full;
    logic                enc_edge, enc_nocount;
    logic [15:0]         reg1_wdata, reg2_wdata;
    logic                drp_abort;

    // Two-flop synchronizer: LOCKED is asynchronous to the reference clock.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_sync_reg <= 2'b00;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], pll_locked};
        end
    end

    assign addr_reg1 = 7'h08 + {4'b0000, sel_reg, 1'b0};
    assign addr_reg2 = addr_reg1 + 7'd1;

    // Divider encoding; LOW of 64 (div 127) truncates to 6'd0 as the PLL expects.
    always_comb begin
        low_full    = div_reg - {1'b0, div_reg[6:1]};
        enc_high    = div_reg[6:1];
        enc_low     = low_full[5:0];
        enc_edge    = div_reg[0];
        enc_nocount = 1'b0;
        if (div_reg == 7'd1) begin
            enc_high    = 6'd1;
            enc_low     = 6'd1;
            enc_edge    = 1'b0;
            enc_nocount = 1'b1;
        end
    end

    assign reg1_wdata = {rdata_reg[15:12], enc_high, enc_low};
    assign reg2_wdata = {rdata_reg[15:8], enc_edge, enc_nocount, rdata_reg[5:0]};

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg      <= ST_HOLD;
            hold_cnt_reg   <= '0;
            drdy_cnt_reg   <= '0;
            lock_cnt_reg   <= '0;
            sel_reg        <= 2'd0;
            div_reg        <= 7'd0;
            rdata_reg      <= 16'd0;
            req_active_reg <= 1'b0;
            pll_rst_reg    <= 1'b1;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            den_reg        <= 1'b0;
            dwe_reg        <= 1'b0;
            daddr_reg      <= 7'd0;
            di_reg         <= 16'd0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            drdy_cnt_reg   <= drdy_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            sel_reg        <= sel_next;
            div_reg        <= div_next;
            rdata_reg      <= rdata_next;
            req_active_reg <= req_active_next;
            pll_rst_reg    <= pll_rst_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            den_reg        <= den_next;
            dwe_reg        <= dwe_next;
            daddr_reg      <= daddr_next;
            di_reg         <= di_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
        drdy_cnt_next   = (drdy_cnt_reg == DRDY_MAX) ? drdy_cnt_reg : drdy_cnt_reg + 1'b1;
        lock_cnt_next   = (lock_cnt_reg == LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
        sel_next        = sel_reg;
        div_next        = div_reg;
        rdata_next      = rdata_reg;
        req_active_next = req_active_reg;
        pll_rst_next    = pll_rst_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        den_next        = 1'b0;
        dwe_next        = 1'b0;
        daddr_next      = daddr_reg;
        di_next         = di_reg;
        drp_abort       = 1'b0;

        case (state_reg)
            // Also entered after the last DRP write so the hold covers both paths.
            ST_HOLD: begin
                if (hold_cnt_reg >= HOLD_LAST) begin
                    pll_rst_next  = 1'b0;
                    lock_cnt_next = '0;
                    state_next    = ST_WAITLOCK;
                end
            end
            ST_WAITLOCK: begin
                if (lock_sync_reg[1]) begin
                    busy_next       = 1'b0;
                    done_next       = req_active_reg;
                    req_active_next = 1'b0;
                    state_next      = ST_IDLE;
                end else if (lock_cnt_reg >= LOCK_LAST) begin
                    busy_next       = 1'b0;
                    err_next        = 1'b1;
                    req_active_next = 1'b0;
                    state_next      = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cfg_req) begin
                    if (cfg_div != 7'd0) begin
                        sel_next        = cfg_out;
                        div_next        = cfg_div;
                        busy_next       = 1'b1;
                        pll_rst_next    = 1'b1;
                        hold_cnt_next   = '0;
                        req_active_next = 1'b1;
                        state_next      = ST_RD1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_RD1: begin
                den_next      = 1'b1;
                daddr_next    = addr_reg1;
                drdy_cnt_next = '0;
                state_next    = ST_WT1;
            end
            ST_WT1: begin
                if (drp.drp_drdy) begin
                    rdata_next = drp.drp_do;
                    state_next = ST_WR1;
                end else if (drdy_cnt_reg >= DRDY_LAST) begin
                    drp_abort = 1'b1;
                end
            end
            ST_WR1: begin
                den_next      = 1'b1;
                dwe_next      = 1'b1;
                daddr_next    = addr_reg1;
                di_next       = reg1_wdata;
                drdy_cnt_next = '0;
                state_next    = ST_WW1;
            end
            ST_WW1: begin
                if (drp.drp_drdy) begin
                    state_next = ST_RD2;
                end else if (drdy_cnt_reg >= DRDY_LAST) begin
                    drp_abort = 1'b1;
                end
            end
            ST_RD2: begin
                den_next      = 1'b1;
                daddr_next    = addr_reg2;
                drdy_cnt_next = '0;
                state_next    = ST_WT2;
            end
            ST_WT2: begin
                if (drp.drp_drdy) begin
                    rdata_next = drp.drp_do;
                    state_next = ST_WR2;
                end else if (drdy_cnt_reg >= DRDY_LAST) begin
                    drp_abort = 1'b1;
                end
            end
            ST_WR2: begin
                den_next      = 1'b1;
                dwe_next      = 1'b1;
                daddr_next    = addr_reg2;
                di_next       = reg2_wdata;
                drdy_cnt_next = '0;
                state_next    = ST_WW2;
            end
            ST_WW2: begin
                if (drp.drp_drdy) begin
                    state_next = ST_HOLD;
                end else if (drdy_cnt_reg >= DRDY_LAST) begin
                    drp_abort = 1'b1;
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase

        // A stuck DRP abandons the request but still lets the PLL relock.
        if (drp_abort) begin
            err_next        = 1'b1;
            pll_rst_next    = 1'b0;
            lock_cnt_next   = '0;
            req_active_next = 1'b0;
            state_next      = ST_WAITLOCK;
        end
    end

    assign cfg_busy      = busy_reg;
    assign cfg_done      = done_reg;
    assign cfg_err       = err_reg;
    assign locked        = lock_sync_reg[1];
    assign pll_rst       = pll_rst_reg;
    assign drp.drp_den   = den_reg;
    assign drp.drp_dwe   = dwe_reg;
    assign drp.drp_daddr = daddr_reg;
    assign drp.drp_di    = di_reg;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Scoreboard bench for pll_drp_ctrl: directed requests push expected DRP
// accesses and done/err events; monitors pop and compare as the DUT emits them.
module tb_pll_drp_ctrl;

    localparam int RST_HOLD     = 16;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 1000;
    localparam int DRP_LAT      = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       cfg_req;
    logic [1:0] cfg_out;
    logic [6:0] cfg_div;
    logic       cfg_busy, cfg_done, cfg_err, locked, pll_rst;
    logic       pll_locked;

    pll_drp_ctrl_if drp_bus();

    pll_drp_ctrl #(
        .RST_HOLD     (RST_HOLD),
        .DRDY_TIMEOUT (DRDY_TIMEOUT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_req    (cfg_req),
        .cfg_out    (cfg_out),
        .cfg_div    (cfg_div),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .pll_locked (pll_locked),
        .drp        (drp_bus)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] data;
    } drp_exp_t;

    typedef enum logic [1:0] {EV_DONE = 2'd1, EV_ERR = 2'd2} ev_t;

    drp_exp_t    drp_q[$];
    ev_t         ev_q[$];
    int          n_vec = 0;
    int          n_mis = 0;
    int          den_total = 0;
    logic [15:0] mem [0:127];
    bit          drdy_en = 1'b1;
    bit          lock_never = 1'b0;
    int          lock_delay = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rmw(input logic [6:0] addr1, input logic [15:0] w1, input logic [15:0] w2);
        drp_q.push_back('{addr: addr1,        we: 1'b0, data: 16'h0000});
        drp_q.push_back('{addr: addr1,        we: 1'b1, data: w1});
        drp_q.push_back('{addr: addr1 + 7'd1, we: 1'b0, data: 16'h0000});
        drp_q.push_back('{addr: addr1 + 7'd1, we: 1'b1, data: w2});
    endtask

    task automatic do_req(input logic [1:0] o, input logic [6:0] d);
        cfg_out = o;
        cfg_div = d;
        cfg_req = 1'b1;
        @(negedge refclk);
        cfg_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (cfg_busy && k < budget) begin
            @(negedge refclk);
            k++;
        end
        check(name, 32'(cfg_busy), 32'd0);
    endtask

    // DRP slave model: fixed latency, optional silence for the timeout case.
    initial begin : drp_model
        logic [6:0]  a;
        logic [15:0] d;
        logic        w;
        drp_bus.drp_drdy = 1'b0;
        drp_bus.drp_do   = 16'h0000;
        forever begin
            @(negedge refclk);
            if (drp_bus.drp_den) begin
                a = drp_bus.drp_daddr;
                d = drp_bus.drp_di;
                w = drp_bus.drp_dwe;
                repeat (DRP_LAT) @(negedge refclk);
                if (drdy_en) begin
                    if (w) mem[a] = d;
                    else   drp_bus.drp_do = mem[a];
                    drp_bus.drp_drdy = 1'b1;
                    @(negedge refclk);
                    drp_bus.drp_drdy = 1'b0;
                end
            end
        end
    end

    // PLL model: LOCKED drops in reset and rises lock_delay cycles after release.
    initial begin : pll_model
        int lcnt;
        lcnt = 0;
        pll_locked = 1'b0;
        forever begin
            @(posedge refclk);
            #2;
            if (pll_rst) begin
                pll_locked = 1'b0;
                lcnt = 0;
            end else if (!lock_never) begin
                if (lcnt >= lock_delay) pll_locked = 1'b1;
                else lcnt++;
            end
        end
    end

    initial begin : mon_drp
        drp_exp_t e;
        forever begin
            @(negedge refclk);
            if (drp_bus.drp_den) begin
                den_total++;
                $display("txn drp addr=0x%02h we=%0d wdata=0x%04h",
                         drp_bus.drp_daddr, drp_bus.drp_dwe, drp_bus.drp_di);
                if (drp_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL drp_unexpected: got addr 0x%0h we %0d, expected no access",
                             drp_bus.drp_daddr, drp_bus.drp_dwe);
                end else begin
                    e = drp_q.pop_front();
                    check("drp_addr", 32'(drp_bus.drp_daddr), 32'(e.addr));
                    check("drp_we", 32'(drp_bus.drp_dwe), 32'(e.we));
                    if (e.we) check("drp_wdata", 32'(drp_bus.drp_di), 32'(e.data));
                end
            end
        end
    end

    initial begin : mon_event
        ev_t got;
        ev_t exp;
        forever begin
            @(negedge refclk);
            if (cfg_done || cfg_err) begin
                got = cfg_done ? EV_DONE : EV_ERR;
                $display("txn event done=%0d err=%0d", cfg_done, cfg_err);
                if (cfg_done && cfg_err) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL event_both: got done and err together, expected one");
                end else if (ev_q.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL event_unexpected: got %s, expected none", got.name());
                end else begin
                    exp = ev_q.pop_front();
                    check("event_kind", 32'(got), 32'(exp));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cnt;
        int d0;
        rst = 1'b1;
        cfg_req = 1'b0;
        cfg_out = 2'd0;
        cfg_div = 7'd0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

        // Power-up: three reset cycles, reset values, 16-cycle hold, lock latency.
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_busy", 32'(cfg_busy), 32'd1);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_den", 32'(drp_bus.drp_den), 32'd0);
        check("rst_dwe", 32'(drp_bus.drp_dwe), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_daddr", 32'(drp_bus.drp_daddr), 32'd0);
        check("rst_di", 32'(drp_bus.drp_di), 32'd0);
        rst = 1'b0;
        cnt = 0;
        while (pll_rst && cnt < 1000) begin
            cnt++;
            @(negedge refclk);
        end
        check("pwrup_rst_len", 32'(cnt), 32'd16);
        cnt = 0;
        while (!pll_locked && cnt < 500) begin
            @(negedge refclk);
            cnt++;
        end
        check("pwrup_pll_locked", 32'(pll_locked), 32'd1);
        cnt = 0;
        while (!locked && cnt < 10) begin
            @(negedge refclk);
            cnt++;
        end
        check("pwrup_lock_latency", 32'(cnt), 32'd2);
        wait_idle(50, "pwrup_idle");
        lock_delay = 20;
        repeat (3) @(negedge refclk);

        // Even divider 40 on CLKOUT2.
        mem[7'h0C] = 16'hF000;
        mem[7'h0D] = 16'hFF3F;
        push_rmw(7'h0C, 16'hF514, 16'hFF3F);
        ev_q.push_back(EV_DONE);
        do_req(2'd2, 7'd40);
        check("t1_busy", 32'(cfg_busy), 32'd1);
        cnt = 0;
        while (pll_rst && cnt < 1000) begin
            cnt++;
            @(negedge refclk);
        end
        check("t1_rst_len_ge16", 32'(cnt >= RST_HOLD), 32'd1);
        wait_idle(300, "t1_idle");
        repeat (3) @(negedge refclk);

        // Odd divider 127 on CLKOUT1: LOW of 64 encodes as zero.
        mem[7'h0A] = 16'h0000;
        mem[7'h0B] = 16'h0000;
        push_rmw(7'h0A, 16'h0FC0, 16'h0080);
        ev_q.push_back(EV_DONE);
        do_req(2'd1, 7'd127);
        wait_idle(300, "t2_idle");
        repeat (3) @(negedge refclk);

        // Divide-by-one on CLKOUT3: NO_COUNT set, EDGE clear.
        mem[7'h0E] = 16'h0000;
        mem[7'h0F] = 16'hFFFF;
        push_rmw(7'h0E, 16'h0041, 16'hFF7F);
        ev_q.push_back(EV_DONE);
        do_req(2'd3, 7'd1);
        wait_idle(300, "t3_idle");
        repeat (3) @(negedge refclk);

        // Illegal divider: error pulse only.
        ev_q.push_back(EV_ERR);
        d0 = den_total;
        do_req(2'd0, 7'd0);
        check("t4_busy", 32'(cfg_busy), 32'd0);
        check("t4_err_now", 32'(cfg_err), 32'd1);
        repeat (10) @(negedge refclk);
        check("t4_no_drp", 32'(den_total - d0), 32'd0);

        // Overlapping request while busy is dropped.
        mem[7'h08] = 16'hA000;
        mem[7'h09] = 16'h12FF;
        push_rmw(7'h08, 16'hA145, 16'h123F);
        ev_q.push_back(EV_DONE);
        d0 = den_total;
        do_req(2'd0, 7'd10);
        repeat (3) @(negedge refclk);
        do_req(2'd3, 7'd5);
        wait_idle(300, "t5_idle");
        repeat (3) @(negedge refclk);
        check("t5_den_count", 32'(den_total - d0), 32'd4);

        // DRDY never arrives: error 64 cycles into WT1, PLL reset released.
        drdy_en = 1'b0;
        drp_q.push_back('{addr: 7'h08, we: 1'b0, data: 16'h0000});
        ev_q.push_back(EV_ERR);
        d0 = den_total;
        do_req(2'd0, 7'd20);
        cnt = 0;
        while (!drp_bus.drp_den && cnt < 10) begin
            @(negedge refclk);
            cnt++;
        end
        cnt = 0;
        while (!cfg_err && cnt < 200) begin
            @(negedge refclk);
            cnt++;
        end
        check("t6_timeout_cycles", 32'(cnt), 32'(DRDY_TIMEOUT));
        check("t6_pll_rst", 32'(pll_rst), 32'd0);
        drdy_en = 1'b1;
        wait_idle(300, "t6_idle");
        repeat (3) @(negedge refclk);
        check("t6_den_count", 32'(den_total - d0), 32'd1);

        // Lock never comes: error after LOCK_TIMEOUT, back to idle.
        lock_never = 1'b1;
        mem[7'h08] = 16'h0000;
        mem[7'h09] = 16'h0000;
        push_rmw(7'h08, 16'h03CF, 16'h0000);
        ev_q.push_back(EV_ERR);
        do_req(2'd0, 7'd30);
        wait_idle(LOCK_TIMEOUT + 500, "t7_idle");
        check("t7_pll_rst", 32'(pll_rst), 32'd0);
        check("t7_locked", 32'(locked), 32'd0);
        lock_never = 1'b0;
        repeat (40) @(negedge refclk);

        // Reset during WW1: strobes stop, full power-up follows, late drdy ignored.
        mem[7'h0C] = 16'h0000;
        drp_q.push_back('{addr: 7'h0C, we: 1'b0, data: 16'h0000});
        drp_q.push_back('{addr: 7'h0C, we: 1'b1, data: 16'h00C3});
        do_req(2'd2, 7'd6);
        cnt = 0;
        while (!(drp_bus.drp_den && drp_bus.drp_dwe) && cnt < 100) begin
            @(negedge refclk);
            cnt++;
        end
        check("t8_reached_ww1", 32'(drp_bus.drp_dwe), 32'd1);
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        check("t8_den", 32'(drp_bus.drp_den), 32'd0);
        check("t8_pll_rst", 32'(pll_rst), 32'd1);
        check("t8_busy", 32'(cfg_busy), 32'd1);
        cnt = 0;
        while (pll_rst && cnt < 1000) begin
            cnt++;
            @(negedge refclk);
        end
        check("t8_rst_len", 32'(cnt), 32'd16);
        wait_idle(300, "t8_idle");
        repeat (20) @(negedge refclk);

        check("drp_queue_empty", 32'(drp_q.size()), 32'd0);
        check("event_queue_empty", 32'(ev_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
